// File: rtl/alu_arb_pkg.sv
// Shared constants for the ALU issue arbiter: opcodes, counter widths,
// and the tag-width helper.
package alu_arb_pkg;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_AND  = 3'd2;
   localparam logic [2:0] OP_OR   = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_SHL  = 3'd5;
   localparam logic [2:0] OP_SHR  = 3'd6;
   localparam logic [2:0] OP_PASS = 3'd7;

   localparam int CNT_W  = 3;
   localparam int STAT_W = 16;

   // Tag width; never below one bit so a 1-wide tag still exists.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      if (r == 0) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set bit of req searching
// from ptr+1 upward, modulo NREQ.
module rr_pick
   import alu_arb_pkg::*;
#(
   parameter int NREQ = 4,
   localparam int TW = clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [TW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [TW-1:0]   idx,
   output logic            any
);

   logic [TW-1:0] pos;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      pos = '0;
      for (int k = 1; k <= NREQ; k++) begin
         pos = TW'((int'(ptr) + k) % NREQ);
         if (!any && req[pos]) begin
            any      = 1'b1;
            gnt[pos] = 1'b1;
            idx      = pos;
         end
      end
   end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Round-robin issue of NREQ requesters onto one pipelined ALU, with
// result routing via a tag shadow pipe. ALU_ARB_STATS_EN adds counters.
module alu_issue_arbiter
   import alu_arb_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int ALU_LAT = 3,
   parameter int MAX_OUT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [3*NREQ-1:0] req_op,
   input  logic [8*NREQ-1:0] req_a,
   input  logic [8*NREQ-1:0] req_b,
   output logic              alu_valid,
   output logic [2:0]        alu_op,
   output logic [7:0]        alu_a,
   output logic [7:0]        alu_b,
   input  logic [7:0]        alu_result,
   output logic [NREQ-1:0]   rsp_valid,
`ifdef ALU_ARB_STATS_EN
   output logic [16*NREQ-1:0] stat_grants,
   output logic [15:0]        stat_idle,
`endif
   output logic [7:0]        rsp_data
);

   localparam int TW = clog2(NREQ);

   logic [NREQ-1:0] elig;
   logic [NREQ-1:0] gnt;
   logic [TW-1:0]   gnt_idx;
   logic            gnt_any;

   logic [2:0] op_arr [NREQ];
   logic [7:0] a_arr  [NREQ];
   logic [7:0] b_arr  [NREQ];

   logic [TW-1:0]    ptr_q, ptr_d;
   logic [CNT_W-1:0] out_cnt_q [NREQ];
   logic [CNT_W-1:0] out_cnt_d [NREQ];

   logic             alu_valid_q, alu_valid_d;
   logic [2:0]       alu_op_q, alu_op_d;
   logic [7:0]       alu_a_q, alu_a_d;
   logic [7:0]       alu_b_q, alu_b_d;
   logic [TW-1:0]    alu_tag_q, alu_tag_d;

   logic             sh_vld_q [ALU_LAT];
   logic             sh_vld_d [ALU_LAT];
   logic [TW-1:0]    sh_tag_q [ALU_LAT];
   logic [TW-1:0]    sh_tag_d [ALU_LAT];

   logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
   logic [7:0]       rsp_data_q, rsp_data_d;

   // Reset masks eligibility so no handshake can occur while in reset.
   always_comb begin
      elig = '0;
      for (int i = 0; i < NREQ; i++) begin
         elig[i] = !reset && req_valid[i]
                   && (out_cnt_q[i] != CNT_W'(MAX_OUT));
         op_arr[i] = req_op[3*i +: 3];
         a_arr[i]  = req_a[8*i +: 8];
         b_arr[i]  = req_b[8*i +: 8];
      end
   end

   rr_pick #(
      .NREQ (NREQ)
   ) u_pick (
      .req (elig),
      .ptr (ptr_q),
      .gnt (gnt),
      .idx (gnt_idx),
      .any (gnt_any)
   );

   assign req_ready = gnt;

   always_comb begin
      ptr_d       = ptr_q;
      alu_valid_d = gnt_any;
      alu_op_d    = alu_op_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_tag_d   = alu_tag_q;
      rsp_valid_d = '0;
      rsp_data_d  = rsp_data_q;
      if (gnt_any) begin
         ptr_d     = gnt_idx;
         alu_op_d  = op_arr[gnt_idx];
         alu_a_d   = a_arr[gnt_idx];
         alu_b_d   = b_arr[gnt_idx];
         alu_tag_d = gnt_idx;
      end
      sh_vld_d[0] = alu_valid_q;
      sh_tag_d[0] = alu_tag_q;
      for (int s = 1; s < ALU_LAT; s++) begin
         sh_vld_d[s] = sh_vld_q[s-1];
         sh_tag_d[s] = sh_tag_q[s-1];
      end
      if (sh_vld_q[ALU_LAT-1]) begin
         rsp_valid_d[sh_tag_q[ALU_LAT-1]] = 1'b1;
         rsp_data_d = alu_result;
      end
      // A slot is released once its response has been presented.
      for (int i = 0; i < NREQ; i++) begin
         out_cnt_d[i] = out_cnt_q[i] + CNT_W'(gnt[i])
                        - CNT_W'(rsp_valid_q[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q       <= TW'(NREQ-1);
         alu_valid_q <= 1'b0;
         alu_op_q    <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_tag_q   <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         for (int i = 0; i < NREQ; i++) out_cnt_q[i] <= '0;
         for (int s = 0; s < ALU_LAT; s++) begin
            sh_vld_q[s] <= 1'b0;
            sh_tag_q[s] <= '0;
         end
      end else begin
         ptr_q       <= ptr_d;
         alu_valid_q <= alu_valid_d;
         alu_op_q    <= alu_op_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_tag_q   <= alu_tag_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         for (int i = 0; i < NREQ; i++) out_cnt_q[i] <= out_cnt_d[i];
         for (int s = 0; s < ALU_LAT; s++) begin
            sh_vld_q[s] <= sh_vld_d[s];
            sh_tag_q[s] <= sh_tag_d[s];
         end
      end
   end

   assign alu_valid = alu_valid_q;
   assign alu_op    = alu_op_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;

`ifdef ALU_ARB_STATS_EN
   logic [STAT_W-1:0] stat_grants_q [NREQ];
   logic [STAT_W-1:0] stat_grants_d [NREQ];
   logic [STAT_W-1:0] stat_idle_q, stat_idle_d;

   always_comb begin
      stat_idle_d = stat_idle_q;
      if (!alu_valid_q && stat_idle_q != '1)
         stat_idle_d = stat_idle_q + 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         stat_grants_d[i] = stat_grants_q[i];
         if (gnt[i] && stat_grants_q[i] != '1)
            stat_grants_d[i] = stat_grants_q[i] + 1'b1;
         stat_grants[16*i +: 16] = stat_grants_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stat_idle_q <= '0;
         for (int i = 0; i < NREQ; i++) stat_grants_q[i] <= '0;
      end else begin
         stat_idle_q <= stat_idle_d;
         for (int i = 0; i < NREQ; i++) stat_grants_q[i] <= stat_grants_d[i];
      end
   end

   assign stat_idle = stat_idle_q;
`endif

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter with a 3-stage ALU model.
// Stats checks run only when ALU_ARB_STATS_EN is defined.
module tb_alu_issue_arbiter;
   import alu_arb_pkg::*;

   logic        clk;
   logic        reset;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [11:0] req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        alu_valid;
   logic [2:0]  alu_op;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [7:0]  alu_result;
   logic [3:0]  rsp_valid;
   logic [7:0]  rsp_data;
`ifdef ALU_ARB_STATS_EN
   logic [63:0] stat_grants;
   logic [15:0] stat_idle;
`endif

   int compared = 0;
   int mismatched = 0;

   alu_issue_arbiter #(
      .NREQ    (4),
      .ALU_LAT (3),
      .MAX_OUT (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .alu_valid  (alu_valid),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_result (alu_result),
      .rsp_valid  (rsp_valid),
`ifdef ALU_ARB_STATS_EN
      .stat_grants(stat_grants),
      .stat_idle  (stat_idle),
`endif
      .rsp_data   (rsp_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] alu_f(input logic [2:0] op,
                                        input logic [7:0] a,
                                        input logic [7:0] b);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_SHL:  return a << b[2:0];
         OP_SHR:  return a >> b[2:0];
         default: return a;
      endcase
   endfunction

   logic [7:0] p0, p1, p2;
   always @(posedge clk) begin
      p0 <= alu_valid ? alu_f(alu_op, alu_a, alu_b) : 8'h00;
      p1 <= p0;
      p2 <= p1;
   end
   assign alu_result = p2;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [2:0] op,
                          input logic [7:0] a, input logic [7:0] b);
      req_op[3*i +: 3] = op;
      req_a[8*i +: 8]  = a;
      req_b[8*i +: 8]  = b;
   endtask

   logic [8:0] rdy_tab;

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      rdy_tab   = 9'b0_1100_0011;

      // Power-on reset
      tick();
      tick();
      chk("rst_ready", req_ready, 4'b0000);
      chk("rst_alu_valid", alu_valid, 1'b0);
      chk("rst_alu_op", alu_op, 3'd0);
      chk("rst_alu_a", alu_a, 8'd0);
      chk("rst_rsp_valid", rsp_valid, 4'b0000);
      chk("rst_rsp_data", rsp_data, 8'd0);
      reset = 1'b0;
      tick();

      // Single ADD from req0: 5 + 7 = 12, response five cycles later
      req_valid = 4'b0001;
      set_req(0, OP_ADD, 8'd5, 8'd7);
      #1;
      chk("single_ready", req_ready, 4'b0001);
      tick();
      req_valid = 4'b0000;
      chk("single_alu_valid", alu_valid, 1'b1);
      chk("single_alu_op", alu_op, OP_ADD);
      chk("single_alu_a", alu_a, 8'd5);
      chk("single_alu_b", alu_b, 8'd7);
      tick();
      chk("single_alu_idle", alu_valid, 1'b0);
      tick();
      tick();
      chk("single_rsp_early", rsp_valid, 4'b0000);
      tick();
      chk("single_rsp_valid", rsp_valid, 4'b0001);
      chk("single_rsp_data", rsp_data, 8'd12);
      tick();
      chk("single_rsp_clear", rsp_valid, 4'b0000);
      chk("single_rsp_hold", rsp_data, 8'd12);
      repeat (3) tick();

      // Wrap-around: ptr parked at 3, then req0 wins over req3
      req_valid = 4'b1000;
      set_req(3, OP_PASS, 8'h33, 8'h00);
      #1;
      chk("wrap_set_ptr", req_ready, 4'b1000);
      tick();
      req_valid = 4'b1001;
      #1;
      chk("wrap_req0_first", req_ready, 4'b0001);
      tick();
      chk("wrap_req3_next", req_ready, 4'b1000);
      tick();
      req_valid = 4'b0000;
      repeat (8) tick();

      // All four requesters continuously, starting with ptr=3
      for (int i = 0; i < 4; i++) set_req(i, OP_ADD, 8'h10 + 8'(i), 8'(i));
      req_valid = 4'b1111;
      for (int k = 0; k < 14; k++) begin
         #1;
         chk("rr_ready", req_ready, 4'b0001 << (k % 4));
         if (k >= 1) begin
            chk("rr_alu_valid", alu_valid, 1'b1);
            chk("rr_alu_a", alu_a, 8'h10 + 8'((k - 1) % 4));
         end
         if (k >= 5) begin
            chk("rr_rsp_valid", rsp_valid, 4'b0001 << ((k - 5) % 4));
            chk("rr_rsp_data", rsp_data, 8'h10 + 8'(2 * ((k - 5) % 4)));
         end else begin
            chk("rr_rsp_idle", rsp_valid, 4'b0000);
         end
         tick();
      end

      // Reset mid-traffic: in-flight ops are dropped
      reset = 1'b1;
      #1;
      chk("mid_rst_ready", req_ready, 4'b0000);
      tick();
      tick();
      chk("mid_rst_alu_valid", alu_valid, 1'b0);
      chk("mid_rst_alu_op", alu_op, 3'd0);
      chk("mid_rst_alu_a", alu_a, 8'd0);
      chk("mid_rst_alu_b", alu_b, 8'd0);
      chk("mid_rst_rsp_valid", rsp_valid, 4'b0000);
      chk("mid_rst_rsp_data", rsp_data, 8'd0);
      reset = 1'b0;
      req_valid = 4'b0000;
      for (int k = 0; k < 7; k++) begin
         chk("mid_rst_dropped", rsp_valid, 4'b0000);
         tick();
      end

      // req2 alone hits MAX_OUT=2; SUB 3-5 = 8'hFE
      set_req(2, OP_SUB, 8'd3, 8'd5);
      req_valid = 4'b0100;
      for (int k = 0; k < 9; k++) begin
         #1;
         chk("maxout_ready", req_ready, rdy_tab[k] ? 4'b0100 : 4'b0000);
         if (k == 5 || k == 6) begin
            chk("maxout_rsp_valid", rsp_valid, 4'b0100);
            chk("maxout_rsp_data", rsp_data, 8'hFE);
         end else begin
            chk("maxout_rsp_idle", rsp_valid, 4'b0000);
         end
         tick();
      end
      req_valid = 4'b0000;
      repeat (8) tick();

`ifdef ALU_ARB_STATS_EN
      // req1 alone: grants in cycles 0,1,6,7,...,24,25 -> 10 grants;
      // 27 cycles counted with 10 issue cycles -> 17 idle
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      set_req(1, OP_XOR, 8'hA5, 8'h0F);
      req_valid = 4'b0010;
      repeat (26) tick();
      req_valid = 4'b0000;
      tick();
      chk("stat_grants1", stat_grants[31:16], 16'd10);
      chk("stat_grants0", stat_grants[15:0], 16'd0);
      chk("stat_idle", stat_idle, 16'd17);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
